// File: rtl/frv_masked_bitwise_pipe.sv
// Two-stage masked bitwise unit (XOR/AND/IOR/NOT/ANDN) over N=D+1 Boolean shares.
// Optional feature macro: FRV_MASKED_BITWISE_CLEAR_EN zeroes idle share registers.
module frv_masked_bitwise_pipe #(
   parameter int BIT_WIDTH = 32,
   parameter int D         = 1
) (
   input  logic                               g_clk,
   input  logic                               g_reset,
   input  logic                               i_flush,
   input  logic                               i_valid,
   output logic                               o_ready,
   input  logic [2:0]                         i_op,
   input  logic [(D+1)*BIT_WIDTH-1:0]         i_a,
   input  logic [(D+1)*BIT_WIDTH-1:0]         i_b,
   input  logic [(D*(D+1)/2)*BIT_WIDTH-1:0]   i_rand_and,
   input  logic [D*BIT_WIDTH-1:0]             i_rand_ref,
   output logic                               o_valid,
   input  logic                               i_ready,
   output logic [(D+1)*BIT_WIDTH-1:0]         o_res,
   output logic                               o_illegal
);

   localparam int N  = D + 1;
   localparam int L  = D * (D + 1) / 2;
   localparam int BW = BIT_WIDTH;

   typedef logic [BW-1:0] word_t;

   // Pairwise randomness index for i<j, row-major over the upper triangle.
   function automatic int pidx(input int i, input int j);
      return i * N - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   logic op_and_cls, op_inv_a0, op_inv_b0, op_inv_c0, op_use_b, op_zero_x, op_ill;

   always_comb begin : decode
      op_and_cls = 1'b0;
      op_inv_a0  = 1'b0;
      op_inv_b0  = 1'b0;
      op_inv_c0  = 1'b0;
      op_use_b   = 1'b0;
      op_zero_x  = 1'b0;
      op_ill     = 1'b0;
      case (i_op)
         3'b000: op_use_b = 1'b1;
         3'b001: op_and_cls = 1'b1;
         3'b010: begin
            op_and_cls = 1'b1;
            op_inv_a0  = 1'b1;
            op_inv_b0  = 1'b1;
            op_inv_c0  = 1'b1;
         end
         3'b011: op_inv_a0 = 1'b1;
         3'b100: begin
            op_and_cls = 1'b1;
            op_inv_b0  = 1'b1;
         end
         // Illegal ops behave as XOR with a=b: a fresh sharing of zero.
         default: begin
            op_zero_x = 1'b1;
            op_ill    = 1'b1;
         end
      endcase
   end

   word_t a_s  [N];
   word_t b_s  [N];
   word_t rr   [N];
   word_t ra   [L];
   word_t rsum;
   logic [N*N-1:0][BW-1:0] t_new;

   // XOR-class results live on the diagonal with zero cross terms, so stage 2
   // reduces both classes with the same row XOR.
   always_comb begin : stage1_terms
      rsum = '0;
      for (int k = 0; k < N; k++) begin
         a_s[k] = i_a[k*BW +: BW];
         b_s[k] = i_b[k*BW +: BW];
         rr[k]  = '0;
      end
      a_s[0] = a_s[0] ^ {BW{op_inv_a0}};
      b_s[0] = b_s[0] ^ {BW{op_inv_b0}};
      for (int k = 0; k < D; k++) begin
         rr[k] = i_rand_ref[k*BW +: BW];
         rsum  = rsum ^ i_rand_ref[k*BW +: BW];
      end
      rr[D] = rsum;
      for (int p = 0; p < L; p++) ra[p] = i_rand_and[p*BW +: BW];
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            t_new[i*N+j] = '0;
            if (op_and_cls) begin
               t_new[i*N+j] = a_s[i] & b_s[j];
               if (i < j)      t_new[i*N+j] = (a_s[i] & b_s[j]) ^ ra[pidx(i, j)];
               else if (i > j) t_new[i*N+j] = (a_s[i] & b_s[j]) ^ ra[pidx(j, i)];
            end else if (i == j) begin
               if (op_zero_x)     t_new[i*N+j] = rr[i];
               else if (op_use_b) t_new[i*N+j] = a_s[i] ^ b_s[i] ^ rr[i];
               else               t_new[i*N+j] = a_s[i] ^ rr[i];
            end
         end
      end
   end

   logic                   s1_valid_q, s1_valid_d;
   logic                   s1_inv_q, s1_inv_d;
   logic                   s1_ill_q, s1_ill_d;
   logic [N*N-1:0][BW-1:0] s1_t_q, s1_t_d;
   logic                   o_valid_q, o_valid_d;
   logic [N*BW-1:0]        o_res_q, o_res_d;
   logic                   o_ill_q, o_ill_d;
   logic [N*BW-1:0]        res_new;
   logic                   adv, accept;

   always_comb begin : stage2_reduce
      res_new = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) res_new[i*BW +: BW] = res_new[i*BW +: BW] ^ s1_t_q[i*N+j];
      end
      res_new[BW-1:0] = res_new[BW-1:0] ^ {BW{s1_inv_q}};
   end

   always_comb begin : control
      adv     = !o_valid_q || i_ready;
      o_ready = !s1_valid_q || adv;
      accept  = i_valid && o_ready && !i_flush;

      s1_valid_d = s1_valid_q;
      s1_inv_d   = s1_inv_q;
      s1_ill_d   = s1_ill_q;
      s1_t_d     = s1_t_q;
      o_valid_d  = o_valid_q;
      o_res_d    = o_res_q;
      o_ill_d    = o_ill_q;

      if (i_flush)     s1_valid_d = 1'b0;
      else if (accept) s1_valid_d = 1'b1;
      else if (adv)    s1_valid_d = 1'b0;

      if (accept) begin
         s1_t_d   = t_new;
         s1_inv_d = op_inv_c0;
         s1_ill_d = op_ill;
      end
`ifdef FRV_MASKED_BITWISE_CLEAR_EN
      else if (!s1_valid_q || adv) begin
         s1_t_d   = '0;
         s1_inv_d = 1'b0;
         s1_ill_d = 1'b0;
      end
`endif

      if (i_flush) begin
         o_valid_d = 1'b0;
      end else if (adv) begin
         o_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            o_res_d = res_new;
            o_ill_d = s1_ill_q;
         end
      end
`ifdef FRV_MASKED_BITWISE_CLEAR_EN
      if (o_valid_q && !o_valid_d) begin
         o_res_d = '0;
         o_ill_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         s1_valid_q <= 1'b0;
         s1_inv_q   <= 1'b0;
         s1_ill_q   <= 1'b0;
         s1_t_q     <= '0;
         o_valid_q  <= 1'b0;
         o_res_q    <= '0;
         o_ill_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_inv_q   <= s1_inv_d;
         s1_ill_q   <= s1_ill_d;
         s1_t_q     <= s1_t_d;
         o_valid_q  <= o_valid_d;
         o_res_q    <= o_res_d;
         o_ill_q    <= o_ill_d;
      end
   end

   assign o_valid   = o_valid_q;
   assign o_res     = o_res_q;
   assign o_illegal = o_ill_q;

endmodule
